// File: rtl/sa_core_reset_seq_if.sv
// Control/status bundle between the software reset sequencer and its core/synchroniser neighbours.
// master drives the request, drain ack and reset feedback; slave is the sequencer itself.
interface sa_core_reset_seq_if;
    logic sw_rst_req;
    logic quiesce_req;
    logic quiesce_ack;
    logic core_reset_rstn;
    logic synced_rstn_fb;
    logic busy;
    logic done;
    logic drain_tmo;
    logic req_dropped;

    modport master (
        output sw_rst_req, quiesce_ack, synced_rstn_fb,
        input  quiesce_req, core_reset_rstn, busy, done, drain_tmo, req_dropped
    );

    modport slave (
        input  sw_rst_req, quiesce_ack, synced_rstn_fb,
        output quiesce_req, core_reset_rstn, busy, done, drain_tmo, req_dropped
    );
endinterface

// File: rtl/sa_core_reset_seq.sv
// Software core-reset sequencer: drain, hold core_reset_rstn low HOLD_CYC cycles, release, await synced feedback.
// Latency: ack already high -> DRAIN 1 cycle after request, HOLD HOLD_CYC cycles; all outputs registered.
// Backpressure: waits on quiesce_ack (bounded by DRAIN_TMO only when SA_RESET_TIMEOUT_EN is defined); busy requests dropped.
module sa_core_reset_seq #(
    parameter int HOLD_CYC  = 16,
    parameter int CNT_W     = 8,
    parameter int DRAIN_TMO = 255
) (
    input  logic                autosa_clk,
    input  logic                dla_reset,
    sa_core_reset_seq_if.slave  ctl
);

    typedef enum logic [2:0] {IDLE, DRAIN, HOLD, RELEASE, DONE} state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

    if (HOLD_CYC < 8 || HOLD_CYC > 255 || HOLD_CYC > (2 ** CNT_W)) begin : g_bad_hold
        $error("sa_core_reset_seq: HOLD_CYC out of range");
    end
    if (DRAIN_TMO < 1 || DRAIN_TMO > (2 ** CNT_W)) begin : g_bad_tmo
        $error("sa_core_reset_seq: DRAIN_TMO out of range");
    end

    state_t           state, next_state;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             fb_seen_low, fb_seen_low_nxt;
    logic             req_dropped_q, req_dropped_nxt;
    logic             quiesce_req_q, core_reset_rstn_q, busy_q, done_q;

`ifdef SA_RESET_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(DRAIN_TMO - 1);
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             drain_tmo_q, drain_tmo_nxt;
`endif

    always_comb begin
        next_state      = state;
        hold_cnt_nxt    = hold_cnt;
        fb_seen_low_nxt = fb_seen_low;
        req_dropped_nxt = req_dropped_q;
`ifdef SA_RESET_TIMEOUT_EN
        tmo_cnt_nxt     = tmo_cnt;
        drain_tmo_nxt   = drain_tmo_q;
`endif
        if (ctl.sw_rst_req && state != IDLE) begin
            req_dropped_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                // quiesce_ack is deliberately not looked at here; it must be seen in DRAIN
                if (ctl.sw_rst_req) begin
                    next_state      = DRAIN;
                    req_dropped_nxt = 1'b0;
`ifdef SA_RESET_TIMEOUT_EN
                    drain_tmo_nxt   = 1'b0;
                    tmo_cnt_nxt     = TMO_LOAD;
`endif
                end
            end
            DRAIN: begin
                if (ctl.quiesce_ack) begin
                    next_state      = HOLD;
                    hold_cnt_nxt    = HOLD_LOAD;
                    fb_seen_low_nxt = 1'b0;
                end
`ifdef SA_RESET_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    next_state      = HOLD;
                    hold_cnt_nxt    = HOLD_LOAD;
                    fb_seen_low_nxt = 1'b0;
                    drain_tmo_nxt   = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt - CNT_W'(1);
                end
`endif
            end
            HOLD: begin
                if (!ctl.synced_rstn_fb) begin
                    fb_seen_low_nxt = 1'b1;
                end
                if (hold_cnt == '0) begin
                    next_state = RELEASE;
                end else begin
                    hold_cnt_nxt = hold_cnt - CNT_W'(1);
                end
            end
            RELEASE: begin
                // a feedback that never went low is stale and must not end the sequence
                if (fb_seen_low && ctl.synced_rstn_fb) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge autosa_clk or posedge dla_reset) begin
        if (dla_reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            fb_seen_low   <= 1'b0;
            req_dropped_q <= 1'b0;
        end else begin
            state         <= next_state;
            hold_cnt      <= hold_cnt_nxt;
            fb_seen_low   <= fb_seen_low_nxt;
            req_dropped_q <= req_dropped_nxt;
        end
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge autosa_clk or posedge dla_reset) begin
        if (dla_reset) begin
            quiesce_req_q     <= 1'b0;
            core_reset_rstn_q <= 1'b1;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            quiesce_req_q     <= (next_state == DRAIN) || (next_state == HOLD);
            core_reset_rstn_q <= (next_state != HOLD);
            busy_q            <= (next_state != IDLE);
            done_q            <= (next_state == DONE);
        end
    end

`ifdef SA_RESET_TIMEOUT_EN
    always_ff @(posedge autosa_clk or posedge dla_reset) begin
        if (dla_reset) begin
            tmo_cnt     <= '0;
            drain_tmo_q <= 1'b0;
        end else begin
            tmo_cnt     <= tmo_cnt_nxt;
            drain_tmo_q <= drain_tmo_nxt;
        end
    end
    assign ctl.drain_tmo = drain_tmo_q;
`else
    assign ctl.drain_tmo = 1'b0;
`endif

    assign ctl.quiesce_req     = quiesce_req_q;
    assign ctl.core_reset_rstn = core_reset_rstn_q;
    assign ctl.busy            = busy_q;
    assign ctl.done            = done_q;
    assign ctl.req_dropped     = req_dropped_q;

endmodule

// File: tb/tb_sa_core_reset_seq.sv
// Directed bench for sa_core_reset_seq; cycle 0 is the cycle the request is presented.
module tb_sa_core_reset_seq;

    logic autosa_clk = 1'b0;
    logic dla_reset  = 1'b0;
    logic fb_force_high;
    logic [5:0] fb_chain;

    sa_core_reset_seq_if ifc ();

    sa_core_reset_seq #(
        .HOLD_CYC  (16),
        .CNT_W     (8),
        .DRAIN_TMO (255)
    ) dut (
        .autosa_clk (autosa_clk),
        .dla_reset  (dla_reset),
        .ctl        (ifc.slave)
    );

    always #5 autosa_clk = ~autosa_clk;

    // Synchroniser stand-in: with the sequencer's own sampling flop, feedback lags rstn by 7 edges.
    always_ff @(posedge autosa_clk or posedge dla_reset) begin
        if (dla_reset) fb_chain <= '1;
        else           fb_chain <= {fb_chain[4:0], ifc.core_reset_rstn};
    end
    assign ifc.synced_rstn_fb = fb_force_high | fb_chain[5];

    int n_checks = 0;
    int n_fail   = 0;
    int first_low, last_low, low_cnt, done_cyc, done_cnt, q_cnt, busy_last, rd_c1;

    task automatic tick();
        @(posedge autosa_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Steps cycles 1..ncyc after a request presented in cycle 0, recording what the outputs did.
    task automatic observe(input int ncyc, input int ack_cyc, input int extra_req_cyc);
        first_low = -1; last_low = -1; low_cnt = 0; done_cyc = -1;
        done_cnt = 0; q_cnt = 0; busy_last = -1; rd_c1 = -1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            ifc.sw_rst_req = (c == extra_req_cyc);
            if (c == ack_cyc) ifc.quiesce_ack = 1'b1;
            if (!ifc.core_reset_rstn) begin
                if (first_low < 0) first_low = c;
                last_low = c;
                low_cnt++;
            end
            if (ifc.done) begin
                if (done_cyc < 0) done_cyc = c;
                done_cnt++;
            end
            if (ifc.quiesce_req && ifc.core_reset_rstn) q_cnt++;
            if (ifc.busy) busy_last = c;
            if (c == 1) rd_c1 = int'(ifc.req_dropped);
        end
    endtask

    task automatic start_req();
        tick();
        ifc.sw_rst_req = 1'b1;
    endtask

    initial begin
        ifc.sw_rst_req  = 1'b0;
        ifc.quiesce_ack = 1'b0;
        fb_force_high   = 1'b0;

        // Reset state
        dla_reset = 1'b1;
        repeat (5) tick();
        chk("rst_rstn",  ifc.core_reset_rstn, 1);
        chk("rst_busy",  ifc.busy,            0);
        chk("rst_done",  ifc.done,            0);
        chk("rst_qreq",  ifc.quiesce_req,     0);
        chk("rst_flags", {ifc.drain_tmo, ifc.req_dropped}, 0);
        dla_reset = 1'b0;
        repeat (3) tick();

        // Nominal: ack high already (also present alongside the request in IDLE)
        ifc.quiesce_ack = 1'b1;
        start_req();
        observe(30, -1, -1);
        chk("nom_first_low", first_low, 2);
        chk("nom_last_low",  last_low,  17);
        chk("nom_low_cnt",   low_cnt,   16);
        chk("nom_drain_cyc", q_cnt,     1);
        chk("nom_done_cyc",  done_cyc,  25);
        chk("nom_done_cnt",  done_cnt,  1);
        chk("nom_busy_last", busy_last, 25);

        // Drain wait: ack raised 40 cycles after the request
        ifc.quiesce_ack = 1'b0;
        start_req();
        observe(70, 40, -1);
        chk("drn_q_cnt",     q_cnt,     40);
        chk("drn_first_low", first_low, 41);
        chk("drn_low_cnt",   low_cnt,   16);
        chk("drn_done_cyc",  done_cyc,  64);
        chk("drn_done_cnt",  done_cnt,  1);

        // Dropped request: second pulse lands in HOLD
        start_req();
        observe(40, -1, 5);
        chk("drp_flag",     ifc.req_dropped, 1);
        chk("drp_done_cnt", done_cnt,        1);
        chk("drp_low_cnt",  low_cnt,         16);

        // Drain timeout (next accepted request must also clear req_dropped)
        ifc.quiesce_ack = 1'b0;
        start_req();
`ifdef SA_RESET_TIMEOUT_EN
        observe(300, -1, -1);
        chk("tmo_rd_clear",  rd_c1,         0);
        chk("tmo_q_cnt",     q_cnt,         255);
        chk("tmo_first_low", first_low,     256);
        chk("tmo_low_cnt",   low_cnt,       16);
        chk("tmo_flag",      ifc.drain_tmo, 1);
`else
        observe(1000, -1, -1);
        chk("tmo_rd_clear", rd_c1,         0);
        chk("tmo_q_cnt",    q_cnt,         1000);
        chk("tmo_low_cnt",  low_cnt,       0);
        chk("tmo_busy",     ifc.busy,      1);
        chk("tmo_flag",     ifc.drain_tmo, 0);
`endif
        ifc.quiesce_ack = 1'b1;
        repeat (40) tick();
        chk("tmo_idle", ifc.busy, 0);

        // Stale feedback: fb never goes low, so the sequence must park in RELEASE
        fb_force_high = 1'b1;
        start_req();
        observe(60, -1, -1);
        chk("stl_done_cnt", done_cnt,        0);
        chk("stl_low_cnt",  low_cnt,         16);
        chk("stl_busy",     ifc.busy,        1);
        chk("stl_qreq",     ifc.quiesce_req, 0);
        dla_reset = 1'b1;
        tick();
        dla_reset = 1'b0;
        fb_force_high = 1'b0;
        repeat (3) tick();

        // Mid-sequence reset during HOLD, then a full clean sequence
        start_req();
        tick();
        ifc.sw_rst_req = 1'b0;
        repeat (4) tick();
        chk("mid_in_hold", ifc.core_reset_rstn, 0);
        dla_reset = 1'b1;
        #1;
        chk("mid_rstn", ifc.core_reset_rstn, 1);
        chk("mid_busy", ifc.busy,            0);
        chk("mid_qreq", ifc.quiesce_req,     0);
        tick();
        dla_reset = 1'b0;
        repeat (2) tick();
        start_req();
        observe(30, -1, -1);
        chk("post_first_low", first_low, 2);
        chk("post_low_cnt",   low_cnt,   16);
        chk("post_done_cyc",  done_cyc,  25);
        chk("post_done_cnt",  done_cnt,  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
